// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - skewed A/B operand feeder with ping-pong matrix store for a systolic PE array
//
// Purpose: accepts one A column and one B row per handshake beat into two
// matrix banks, then streams each full bank as a gap-free burst of DIMENSION
// beats to the array edges. Lane k is delayed by k extra cycles, and every
// lane carries its own PE reset next to its data.
//
// Ports:
//   i_clock        clock
//   i_reset        synchronous reset, active-high
//   i_valid        upstream beat valid
//   o_ready        a bank can take a beat (low only when both banks are full)
//   i_a_vec        A[:,k], lane r = bits [r*I_BITS +: I_BITS]
//   i_b_vec        B[k,:], lane c = bits [c*I_BITS +: I_BITS]
//   o_a, o_b       skewed operands to array rows / columns
//   o_a_reset      per-row PE reset, skewed with o_a
//   o_b_reset      per-column PE reset, skewed with o_b
//   o_busy         streaming, or data / done pulse still in flight
//   o_matrix_done  one-cycle pulse when PE(D-1,D-1) shows its result
//   o_gap_count    (FEEDER_STATS_EN only) saturating count of GAP cycles
//
// Configuration macro: FEEDER_STATS_EN adds o_gap_count.

module systolic_skew_feeder #(
    parameter int DIMENSION = 4,
    parameter int I_BITS    = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [DIMENSION*I_BITS-1:0]   i_a_vec,
    input  logic [DIMENSION*I_BITS-1:0]   i_b_vec,
    output logic [DIMENSION*I_BITS-1:0]   o_a,
    output logic [DIMENSION*I_BITS-1:0]   o_b,
    output logic [DIMENSION-1:0]          o_a_reset,
    output logic [DIMENSION-1:0]          o_b_reset,
    output logic                          o_busy,
    output logic                          o_matrix_done
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]                   o_gap_count
`endif
);

    localparam int VW = DIMENSION * I_BITS;
    localparam int IW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
    localparam logic [IW-1:0] LAST_BEAT = IW'(DIMENSION - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      bank_full;
    logic            wr_sel;
    logic            rd_sel;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   beat;

    logic [VW-1:0]   mem_a [2][DIMENSION];
    logic [VW-1:0]   mem_b [2][DIMENSION];

    logic            accept;
    logic            last_issue;
    logic [VW-1:0]   slot_a;
    logic [VW-1:0]   slot_b;
    logic            slot_rst;

    logic [2*DIMENSION-1:0] done_sr;
    logic [DIMENSION-1:0]   lane_live;

    assign o_ready    = ~&bank_full;
    assign accept     = i_valid && o_ready;
    assign last_issue = (state == ST_STREAM) && (beat == LAST_BEAT);

    // Matrix store. No reset needed: bank_full and the indices gate every read.
    always_ff @(posedge i_clock) begin
        if (accept) begin
            mem_a[wr_sel][wr_idx] <= i_a_vec;
            mem_b[wr_sel][wr_idx] <= i_b_vec;
        end
    end

    // Write side and issue FSM. Banks are consumed in the order they were
    // filled, so one toggling pointer per side keeps them in step; the write
    // pointer can only land on a full bank when both banks are full.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            bank_full <= 2'b00;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_idx    <= '0;
            beat      <= '0;
        end else begin
            if (accept) begin
                if (wr_idx == LAST_BEAT) begin
                    bank_full[wr_sel] <= 1'b1;
                    wr_sel            <= ~wr_sel;
                    wr_idx            <= '0;
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end

            case (state)
                ST_IDLE, ST_GAP: begin
                    if (bank_full[rd_sel]) begin
                        state <= ST_STREAM;
                        beat  <= '0;
                    end
                end
                ST_STREAM: begin
                    if (beat == LAST_BEAT) begin
                        bank_full[rd_sel] <= 1'b0;
                        rd_sel            <= ~rd_sel;
                        beat              <= '0;
                        // Chain straight into the next matrix only if it was
                        // already full this cycle; a bank completing on this
                        // same edge costs exactly one GAP cycle.
                        state <= bank_full[~rd_sel] ? ST_STREAM : ST_GAP;
                    end else begin
                        beat <= beat + IW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Issue slot for this cycle; outside a burst it carries the PE reset.
    always_comb begin
        slot_a   = '0;
        slot_b   = '0;
        slot_rst = 1'b1;
        if (state == ST_STREAM) begin
            slot_a   = mem_a[rd_sel][beat];
            slot_b   = mem_b[rd_sel][beat];
            slot_rst = 1'b0;
        end
    end

    // Done timing: lane D-1 lands D cycles after issue, then D-1 PE hops and
    // the accumulate edge. A plain shift line keeps one timestamp per matrix,
    // so overlapping matrices each get their own pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            done_sr <= '0;
        end else begin
            done_sr <= {done_sr[2*DIMENSION-2:0], last_issue};
        end
    end

    assign o_matrix_done = done_sr[2*DIMENSION-1];

    // Skew pipes: lane r is r+1 registers deep. A and B lanes share one reset
    // pipe since both edges see the same slot reset.
    for (genvar r = 0; r < DIMENSION; r++) begin : g_lane
        logic [I_BITS-1:0] a_sr [0:r];
        logic [I_BITS-1:0] b_sr [0:r];
        logic [r:0]        rst_sr;

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                for (int s = 0; s <= r; s++) begin
                    a_sr[s] <= '0;
                    b_sr[s] <= '0;
                end
                rst_sr <= '1;
            end else begin
                a_sr[0]   <= slot_a[r*I_BITS +: I_BITS];
                b_sr[0]   <= slot_b[r*I_BITS +: I_BITS];
                rst_sr[0] <= slot_rst;
                for (int s = 1; s <= r; s++) begin
                    a_sr[s]   <= a_sr[s-1];
                    b_sr[s]   <= b_sr[s-1];
                    rst_sr[s] <= rst_sr[s-1];
                end
            end
        end

        assign o_a[r*I_BITS +: I_BITS] = a_sr[r];
        assign o_b[r*I_BITS +: I_BITS] = b_sr[r];
        assign o_a_reset[r]            = rst_sr[r];
        assign o_b_reset[r]            = rst_sr[r];
        assign lane_live[r]            = ~&rst_sr;
    end

    assign o_busy = (state == ST_STREAM) || (|lane_live) || (|done_sr);

`ifdef FEEDER_STATS_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_gap_count <= '0;
        end else if ((state == ST_GAP) && (o_gap_count != 16'hFFFF)) begin
            o_gap_count <= o_gap_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - self-checking bench for systolic_skew_feeder

module tb_systolic_skew_feeder;

    localparam int D    = 4;
    localparam int IB   = 8;
    localparam int VW   = D * IB;
    localparam int MAXC = 4096;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_valid = 1'b0;
    logic [VW-1:0] i_a_vec = '0;
    logic [VW-1:0] i_b_vec = '0;
    logic          o_ready;
    logic [VW-1:0] o_a;
    logic [VW-1:0] o_b;
    logic [D-1:0]  o_a_reset;
    logic [D-1:0]  o_b_reset;
    logic          o_busy;
    logic          o_matrix_done;
`ifdef FEEDER_STATS_EN
    logic [15:0]   o_gap_count;
`endif

    systolic_skew_feeder #(.DIMENSION(D), .I_BITS(IB)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_a_vec       (i_a_vec),
        .i_b_vec       (i_b_vec),
        .o_a           (o_a),
        .o_b           (o_b),
        .o_a_reset     (o_a_reset),
        .o_b_reset     (o_b_reset),
        .o_busy        (o_busy),
        .o_matrix_done (o_matrix_done)
`ifdef FEEDER_STATS_EN
        ,
        .o_gap_count   (o_gap_count)
`endif
    );

    always #5 i_clock = ~i_clock;

    // Reference model: a timeline of issue slots and burst end cycles.
    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc         = 0;
    bit            mon_en      = 1'b0;
    bit            slot_v  [MAXC];
    logic [VW-1:0] slot_a  [MAXC];
    logic [VW-1:0] slot_b  [MAXC];
    bit            tlast_f [MAXC];
    int            pend_ft [$];
    int            pend_fr [$];
    int            nbeat;
    int            prev_last;
    int            last_start;
    int            last_done;
    logic [VW-1:0] pa [D];
    logic [VW-1:0] pb [D];
    logic [VW-1:0] wa [D];
    logic [VW-1:0] wb [D];

    logic [VW-1:0] m_a, m_b;
    logic [D-1:0]  m_r;
    bit            m_done, m_busy, m_rdy;

    function automatic bit sv(int s);
        return (s >= 0 && s < MAXC) ? slot_v[s] : 1'b0;
    endfunction

    function automatic bit tl(int s);
        return (s >= 0 && s < MAXC) ? tlast_f[s] : 1'b0;
    endfunction

    // A bank counts as full from the cycle after its last write until the
    // cycle after its last issue; ready drops only with two such banks.
    function automatic bit model_ready(int c);
        int n = 0;
        foreach (pend_ft[i]) if (pend_ft[i] <= c && c < pend_fr[i]) n++;
        return n < 2;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < MAXC; i++) begin
            slot_v[i]  = 1'b0;
            tlast_f[i] = 1'b0;
        end
        pend_ft.delete();
        pend_fr.delete();
        nbeat     = 0;
        prev_last = -100;
    endtask

    // A matrix full at cycle ft starts streaming the cycle after the streamer
    // sees it, but never before the previous burst has ended.
    task automatic finalize(input int ft);
        int st;
        st = (prev_last + 1 > ft + 1) ? prev_last + 1 : ft + 1;
        for (int k = 0; k < D; k++) begin
            slot_v[st+k] = 1'b1;
            slot_a[st+k] = pa[k];
            slot_b[st+k] = pb[k];
        end
        prev_last          = st + D - 1;
        tlast_f[prev_last] = 1'b1;
        last_start         = st;
        last_done          = prev_last + 2 * D;
        pend_ft.push_back(ft);
        pend_fr.push_back(st + D);
    endtask

    task automatic step();
        bit acc;
        acc = i_valid && model_ready(cyc) && !i_reset;
        @(posedge i_clock);
        #1;
        if (i_reset) begin
            model_clear();
        end else if (acc) begin
            pa[nbeat] = i_a_vec;
            pb[nbeat] = i_b_vec;
            nbeat++;
            if (nbeat == D) begin
                finalize(cyc + 1);
                nbeat = 0;
            end
        end
        cyc++;
    endtask

    task automatic write_matrix(input bit toggle);
        int k = 0;
        int guard = 0;
        bit acc;
        while (k < D && guard < 200) begin
            i_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            i_a_vec = wa[k];
            i_b_vec = wb[k];
            acc = i_valid && model_ready(cyc);
            step();
            if (acc) k++;
            guard++;
        end
        i_valid = 1'b0;
        vectors++;
        if (k != D) begin
            miscompares++;
            $display("FAIL write_timeout beats=%0d required=%0d", k, D);
        end
    endtask

    task automatic rand_matrix();
        for (int k = 0; k < D; k++) begin
            wa[k] = $urandom;
            wb[k] = $urandom;
        end
    endtask

    // Cycle-by-cycle scoreboard against the model timeline.
    always @(negedge i_clock) begin
        if (mon_en) begin
            for (int r = 0; r < D; r++) begin
                if (sv(cyc - 1 - r)) begin
                    m_a[r*IB +: IB] = slot_a[cyc-1-r][r*IB +: IB];
                    m_b[r*IB +: IB] = slot_b[cyc-1-r][r*IB +: IB];
                    m_r[r]          = 1'b0;
                end else begin
                    m_a[r*IB +: IB] = '0;
                    m_b[r*IB +: IB] = '0;
                    m_r[r]          = 1'b1;
                end
            end
            m_done = tl(cyc - 2 * D);
            m_busy = sv(cyc);
            for (int j = 1; j <= D; j++) if (sv(cyc - j)) m_busy = 1'b1;
            for (int j = 1; j <= 2 * D; j++) if (tl(cyc - j)) m_busy = 1'b1;
            m_rdy = model_ready(cyc);

            vectors += 7;
            if (o_a !== m_a) begin
                miscompares++;
                $display("FAIL o_a cyc=%0d got=%h exp=%h", cyc, o_a, m_a);
            end
            if (o_b !== m_b) begin
                miscompares++;
                $display("FAIL o_b cyc=%0d got=%h exp=%h", cyc, o_b, m_b);
            end
            if (o_a_reset !== m_r) begin
                miscompares++;
                $display("FAIL o_a_reset cyc=%0d got=%b exp=%b", cyc, o_a_reset, m_r);
            end
            if (o_b_reset !== m_r) begin
                miscompares++;
                $display("FAIL o_b_reset cyc=%0d got=%b exp=%b", cyc, o_b_reset, m_r);
            end
            if (o_matrix_done !== m_done) begin
                miscompares++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, o_matrix_done, m_done);
            end
            if (o_busy !== m_busy) begin
                miscompares++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, m_busy);
            end
            if (o_ready !== m_rdy) begin
                miscompares++;
                $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, o_ready, m_rdy);
            end
        end
    end

    task automatic test_reset();
        i_reset = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        i_reset = 1'b0;
        vectors++;
        if (o_a !== '0 || o_b !== '0 || o_a_reset !== 4'b1111 || o_b_reset !== 4'b1111 ||
            o_ready !== 1'b1 || o_busy !== 1'b0 || o_matrix_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got a=%h b=%h ar=%b br=%b rdy=%b busy=%b done=%b required 0 0 1111 1111 1 0 0",
                     o_a, o_b, o_a_reset, o_b_reset, o_ready, o_busy, o_matrix_done);
        end
    endtask

    task automatic test_single();
        int done_seen = -1;
        for (int k = 0; k < D; k++) begin
            for (int r = 0; r < D; r++) begin
                wa[k][r*IB +: IB] = (r == k) ? 8'd1 : 8'd0;
                wb[k][r*IB +: IB] = 8'((r + 1) * (k + 1));
            end
        end
        write_matrix(1'b0);
        while (cyc < last_done + 2) begin
            step();
            if (cyc == last_start + 1) begin
                vectors++;
                if (o_a_reset !== 4'b1110 || o_a[IB-1:0] !== wa[0][IB-1:0] || o_b[IB-1:0] !== wb[0][IB-1:0]) begin
                    miscompares++;
                    $display("FAIL first_lane got ar=%b a0=%h b0=%h required 1110 %h %h",
                             o_a_reset, o_a[IB-1:0], o_b[IB-1:0], wa[0][IB-1:0], wb[0][IB-1:0]);
                end
            end
            if (o_matrix_done === 1'b1 && done_seen < 0) done_seen = cyc;
        end
        vectors++;
        if (done_seen != last_done) begin
            miscompares++;
            $display("FAIL single_done_cycle got=%0d required=%0d", done_seen, last_done);
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        int d0 = -1;
        int d1 = -1;
        rand_matrix();
        write_matrix(1'b0);
        t1 = prev_last;
        rand_matrix();
        write_matrix(1'b0);
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_both_full got=%b required=0", o_ready);
        end
        while (cyc < t1 + 3 * D + 2) begin
            step();
            if (cyc == t1 + 2) begin
                vectors++;
                if (o_a_reset[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL no_reset_between got=%b required=0", o_a_reset[0]);
                end
            end
            if (o_matrix_done === 1'b1) begin
                if (d0 < 0) d0 = cyc;
                else if (d1 < 0) d1 = cyc;
            end
        end
        vectors += 2;
        if (d0 != t1 + 2 * D) begin
            miscompares++;
            $display("FAIL b2b_first_done got=%0d required=%0d", d0, t1 + 2 * D);
        end
        if (d1 - d0 != D) begin
            miscompares++;
            $display("FAIL b2b_done_spacing got=%0d required=%0d", d1 - d0, D);
        end
    endtask

    task automatic test_late_gap();
        int t1;
        rand_matrix();
        write_matrix(1'b0);
        t1 = prev_last;
        while (cyc < t1 + 5) begin
            step();
            for (int r = 0; r < D; r++) begin
                if (cyc == t1 + 2 + r) begin
                    vectors++;
                    if (o_a_reset[r] !== 1'b1 || o_b_reset[r] !== 1'b1) begin
                        miscompares++;
                        $display("FAIL gap_lane_reset lane=%0d got=%b%b required=11", r, o_a_reset[r], o_b_reset[r]);
                    end
                end
            end
        end
        rand_matrix();
        write_matrix(1'b0);
        repeat (3 * D + 2) step();
    endtask

    task automatic test_valid_toggle();
        int first = -1;
        int last  = -1;
        int n     = 0;
        rand_matrix();
        write_matrix(1'b1);
        while (cyc < last_done + 2) begin
            step();
            if (o_a_reset[0] === 1'b0) begin
                if (first < 0) first = cyc;
                last = cyc;
                n++;
            end
        end
        vectors += 2;
        if (n != D) begin
            miscompares++;
            $display("FAIL toggle_burst_len got=%0d required=%0d", n, D);
        end
        if (last - first != D - 1) begin
            miscompares++;
            $display("FAIL toggle_burst_contig got=%0d required=%0d", last - first, D - 1);
        end
    endtask

    task automatic test_mid_reset();
        int st;
        int pulses = 0;
        rand_matrix();
        write_matrix(1'b0);
        st = last_start;
        while (cyc < st + 2) step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        vectors++;
        if (o_a !== '0 || o_b !== '0 || o_a_reset !== 4'b1111 || o_b_reset !== 4'b1111 ||
            o_ready !== 1'b1 || o_busy !== 1'b0 || o_matrix_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state got a=%h b=%h ar=%b br=%b rdy=%b busy=%b done=%b required 0 0 1111 1111 1 0 0",
                     o_a, o_b, o_a_reset, o_b_reset, o_ready, o_busy, o_matrix_done);
        end
        repeat (3 * D) begin
            step();
            if (o_matrix_done === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL midreset_done_pulses got=%0d required=0", pulses);
        end
    endtask

    task automatic test_random();
        for (int m = 0; m < 6; m++) begin
            rand_matrix();
            repeat ($urandom_range(0, 6)) step();
            write_matrix(1'($urandom_range(0, 1)));
        end
        repeat (3 * D + 4) step();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_back_to_back();
        test_late_gap();
        test_valid_toggle();
        test_mid_reset();
        test_random();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
